// File: rtl/sram_pkg.sv
// Shared SRAM-side definitions: dump engine states, header length and the SRAM byte-address width.
package sram_pkg;

  localparam int SRAM_ADDR_W = 19;
  localparam int HDR_BYTES   = 8;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_READ  = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_CSUM  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/sram_dump_if.sv
// UART receive, SRAM read port and UART transmit signals of the dump engine; master is the engine side.
interface sram_dump_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
);
  logic [7:0]        uart_data;
  logic              uart_recv;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_load;
  logic [7:0]        ram_indata;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;

  modport master (
    output ram_address, ram_load, tx_data, tx_send,
    input  uart_data, uart_recv, ram_indata, tx_busy
  );

  modport slave (
    input  ram_address, ram_load, tx_data, tx_send,
    output uart_data, uart_recv, ram_indata, tx_busy
  );
endinterface

// File: rtl/sram_dump_txsync.sv
// Synchronises the slow-domain tx_busy and runs one request/ack/drain handshake per byte with uarttx.
// abort_i drops the request at once; a byte uarttx already took still finishes on the wire.
module sram_dump_txsync (
  input  logic       clock4,
  input  logic       resetn,
  input  logic       abort_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_send_o,
  output logic       acked_o,
  output logic       done_o
);
  typedef enum logic [1:0] {H_IDLE, H_SEND, H_DRAIN} hs_e;

  hs_e        hs_q;
  logic       busy_s1_q, busy_s2_q;
  logic [7:0] tx_data_q;
  logic       tx_send_q;

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      hs_q      <= H_IDLE;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      busy_s1_q <= tx_busy_i;
      busy_s2_q <= busy_s1_q;
      if (abort_i) begin
        hs_q      <= H_IDLE;
        tx_send_q <= 1'b0;
      end else begin
        case (hs_q)
          H_IDLE: if (start_i) begin
            tx_data_q <= data_i;
            tx_send_q <= 1'b1;
            hs_q      <= H_SEND;
          end
          H_SEND: if (busy_s2_q) begin
            tx_send_q <= 1'b0;
            hs_q      <= H_DRAIN;
          end
          H_DRAIN: if (!busy_s2_q) hs_q <= H_IDLE;
          default: hs_q <= H_IDLE;
        endcase
      end
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_send_o = tx_send_q;
  assign acked_o   = (hs_q == H_SEND) && busy_s2_q;
  assign done_o    = (hs_q == H_DRAIN) && !busy_s2_q;
endmodule

// File: rtl/sram_dump.sv
// UART-commanded SRAM readback: 8-byte big-endian address/count header, then count bytes streamed to uarttx.
// Define SRAM_DUMP_CHECKSUM_EN to append a mod-256 sum byte after every non-empty dump.
module sram_dump
  import sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int READ_WAIT = 2
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic        dump,
  sram_dump_if.master bus,
  output logic        active
);
  dump_state_e       state_q;
  logic [2:0]        hdr_idx_q;
  logic [31:0]       addr_q;
  logic [31:0]       count_q;
  logic [3:0]        wait_q;
  logic              recv_d_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_load_q;
  logic              active_q;
  logic              new_byte;
  logic              tx_start;
  logic              tx_acked;
  logic              tx_done;
  logic [7:0]        tx_byte;
  logic [7:0]        tx_data_w;
  logic              tx_send_w;
  logic [31:0]       count_shift;
  logic [31:0]       addr_next;
`ifdef SRAM_DUMP_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign new_byte    = bus.uart_recv & ~recv_d_q;
  assign count_shift = {count_q[23:0], bus.uart_data};
  // Only the SRAM-visible bits advance, so the address wraps inside the device.
  assign addr_next   = {addr_q[31:ADDR_W], addr_q[ADDR_W-1:0] + ADDR_W'(1)};

  always_comb begin
    tx_start = 1'b0;
    tx_byte  = bus.ram_indata;
    if (state_q == S_READ && wait_q == 4'd0) tx_start = 1'b1;
`ifdef SRAM_DUMP_CHECKSUM_EN
    if (state_q == S_CSUM) begin
      tx_start = 1'b1;
      tx_byte  = sum_q;
    end
`endif
  end

  sram_dump_txsync u_txsync (
    .clock4    (clock4),
    .resetn    (resetn),
    .abort_i   (~dump),
    .start_i   (tx_start),
    .data_i    (tx_byte),
    .tx_busy_i (bus.tx_busy),
    .tx_data_o (tx_data_w),
    .tx_send_o (tx_send_w),
    .acked_o   (tx_acked),
    .done_o    (tx_done)
  );

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_HDR;
      hdr_idx_q     <= 3'd0;
      addr_q        <= 32'd0;
      count_q       <= 32'd0;
      wait_q        <= 4'd0;
      recv_d_q      <= 1'b0;
      ram_address_q <= '0;
      ram_load_q    <= 1'b0;
      active_q      <= 1'b0;
`ifdef SRAM_DUMP_CHECKSUM_EN
      sum_q         <= 8'h00;
`endif
    end else if (!dump) begin
      state_q    <= S_HDR;
      hdr_idx_q  <= 3'd0;
      ram_load_q <= 1'b0;
      active_q   <= 1'b0;
      recv_d_q   <= 1'b0;
    end else begin
      recv_d_q <= bus.uart_recv;
      case (state_q)
        S_HDR: if (new_byte) begin
          active_q  <= 1'b1;
          hdr_idx_q <= hdr_idx_q + 3'd1;
          if (!hdr_idx_q[2]) addr_q  <= {addr_q[23:0], bus.uart_data};
          else               count_q <= count_shift;
          if (hdr_idx_q == 3'(HDR_BYTES - 1)) begin
            if (count_shift == 32'd0) begin
              active_q <= 1'b0;
            end else begin
              state_q       <= S_READ;
              ram_address_q <= addr_q[ADDR_W-1:0];
              ram_load_q    <= 1'b1;
              wait_q        <= 4'(READ_WAIT);
`ifdef SRAM_DUMP_CHECKSUM_EN
              sum_q         <= 8'h00;
`endif
            end
          end
        end
        S_READ: begin
          if (wait_q == 4'd0) begin
            ram_load_q <= 1'b0;
            state_q    <= S_SEND;
`ifdef SRAM_DUMP_CHECKSUM_EN
            sum_q      <= sum_q + bus.ram_indata;
`endif
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_SEND: if (tx_acked) state_q <= S_DRAIN;
        S_DRAIN: if (tx_done) begin
`ifdef SRAM_DUMP_CHECKSUM_EN
          // count is already zero only after the checksum byte itself drained.
          if (count_q == 32'd0) begin
            state_q  <= S_HDR;
            active_q <= 1'b0;
          end else begin
            addr_q  <= addr_next;
            count_q <= count_q - 32'd1;
            if (count_q == 32'd1) begin
              state_q <= S_CSUM;
            end else begin
              state_q       <= S_READ;
              ram_address_q <= addr_next[ADDR_W-1:0];
              ram_load_q    <= 1'b1;
              wait_q        <= 4'(READ_WAIT);
            end
          end
`else
          addr_q  <= addr_next;
          count_q <= count_q - 32'd1;
          if (count_q == 32'd1) begin
            state_q  <= S_HDR;
            active_q <= 1'b0;
          end else begin
            state_q       <= S_READ;
            ram_address_q <= addr_next[ADDR_W-1:0];
            ram_load_q    <= 1'b1;
            wait_q        <= 4'(READ_WAIT);
          end
`endif
        end
        S_CSUM: state_q <= S_SEND;
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_load    = ram_load_q;
  assign bus.tx_data     = tx_data_w;
  assign bus.tx_send     = tx_send_w;
  assign active          = active_q;
endmodule

// File: tb/tb_sram_dump.sv
`timescale 1ns/1ps
module tb_sram_dump;
  import sram_pkg::*;

  localparam int AW = SRAM_ADDR_W;

  logic clock4 = 1'b0;
  logic resetn = 1'b0;
  logic dump   = 1'b0;
  logic active;

  sram_dump_if #(.ADDR_W(AW)) bus ();

  sram_dump #(.ADDR_W(AW), .READ_WAIT(2)) dut (
    .clock4 (clock4),
    .resetn (resetn),
    .dump   (dump),
    .bus    (bus.master),
    .active (active)
  );

  always #5 clock4 = ~clock4;

  logic [7:0] mem [0:(1<<AW)-1];
  assign bus.ram_indata = mem[bus.ram_address];

  logic [7:0] got_q[$];
  logic       saw_load = 1'b0;
  logic       saw_send = 1'b0;
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uarttx model: takes a byte on tx_send while idle, then stays busy for a random time.
  initial begin
    int busy_left;
    busy_left   = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clock4); #1;
      if (bus.ram_load) saw_load = 1'b1;
      if (bus.tx_send)  saw_send = 1'b1;
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_send) begin
        got_q.push_back(bus.tx_data);
        bus.tx_busy = 1'b1;
        busy_left   = $urandom_range(4, 12);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clock4); #1;
    bus.uart_data = b;
    bus.uart_recv = 1'b1;
    repeat (hold) @(posedge clock4);
    #1 bus.uart_recv = 1'b0;
    repeat (2) @(posedge clock4);
  endtask

  task automatic send_header(input logic [31:0] a, input logic [31:0] c, input int hold_max,
                             input bit check_first);
    logic [63:0] h;
    h = {a, c};
    for (int i = 0; i < 8; i++) begin
      send_byte(h[63-8*i -: 8], $urandom_range(1, hold_max));
      if (check_first && i == 0) check("active_first_byte", active, 1'b1);
    end
  endtask

  // Waits for the dump to finish; optionally throws stray UART bytes at the engine meanwhile.
  task automatic wait_idle(input string tag, input bit inject);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clock4); #1;
      if (!active) break;
      if (inject && $urandom_range(0, 5) == 0) begin
        bus.uart_recv = ~bus.uart_recv;
        bus.uart_data = 8'($urandom);
      end
    end
    bus.uart_recv = 1'b0;
    repeat (3) @(posedge clock4);
    #1 check({tag, "_idle"}, active, 1'b0);
  endtask

  task automatic compare_run(input string tag, input logic [31:0] a, input int n);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[(a + 32'(i)) % (32'd1 << AW)]);
      sum = sum + exp_q[i];
    end
`ifdef SRAM_DUMP_CHECKSUM_EN
    if (n > 0) exp_q.push_back(sum);
`endif
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  task automatic fill_random(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) mem[(a + 32'(i)) % (32'd1 << AW)] = 8'($urandom);
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    int          kept;
    bus.uart_data = 8'h00;
    bus.uart_recv = 1'b0;

    repeat (3) @(posedge clock4);
    #1;
    check("rst_ram_address", 64'(bus.ram_address), 0);
    check("rst_ram_load", bus.ram_load, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_tx_send", bus.tx_send, 1'b0);
    check("rst_active", active, 1'b0);
    resetn = 1'b1;
    dump   = 1'b1;
    repeat (2) @(posedge clock4);

    // Basic three-byte dump.
    mem[32'h100] = 8'hAA;
    mem[32'h101] = 8'hBB;
    mem[32'h102] = 8'hCC;
    send_header(32'h0000_0100, 32'd3, 1, 1'b1);
    check("basic_active_after_hdr", active, 1'b1);
    wait_idle("basic", 1'b0);
    compare_run("basic", 32'h100, 3);

    // Zero count: header consumed, nothing read or sent.
    saw_load = 1'b0;
    saw_send = 1'b0;
    send_header(32'h0000_0200, 32'd0, 3, 1'b0);
    repeat (20) @(posedge clock4);
    #1;
    check("zero_active", active, 1'b0);
    check("zero_no_load", saw_load, 1'b0);
    check("zero_no_send", saw_send, 1'b0);
    check("zero_no_bytes", 64'(got_q.size()), 0);

    // Address wrap at the top of SRAM.
    mem[32'h7FFFF] = 8'h11;
    mem[32'h00000] = 8'h22;
    send_header(32'h0007_FFFF, 32'd2, 2, 1'b0);
    wait_idle("wrap", 1'b0);
    compare_run("wrap", 32'h0007_FFFF, 2);

    // Long recv levels plus stray bytes during transmission.
    fill_random(32'h0001_2345, 4);
    send_header(32'h0001_2345, 32'd4, 50, 1'b0);
    wait_idle("hold50", 1'b1);
    compare_run("hold50", 32'h0001_2345, 4);

    // Random headers; upper address bits must be ignored.
    for (int t = 0; t < 4; t++) begin
      a = $urandom;
      n = $urandom_range(1, 6);
      fill_random(a, n);
      send_header(a, 32'(n), $urandom_range(1, 8), 1'b0);
      wait_idle($sformatf("rnd%0d", t), 1'(t & 1));
      compare_run($sformatf("rnd%0d", t), a, n);
    end

    // Abort while the second of five bytes is being requested.
    fill_random(32'h300, 5);
    send_header(32'h0000_0300, 32'd5, 2, 1'b0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clock4); #2;
      if (got_q.size() == 2 && bus.tx_send) break;
    end
    check("abort_reached_byte2", 64'(got_q.size()), 2);
    check("abort_send_high", bus.tx_send, 1'b1);
    dump = 1'b0;
    @(posedge clock4); #1;
    check("abort_tx_send", bus.tx_send, 1'b0);
    check("abort_ram_load", bus.ram_load, 1'b0);
    check("abort_active", active, 1'b0);
    kept = got_q.size();
    repeat (100) @(posedge clock4);
    #1;
    check("abort_no_more_bytes", 64'(got_q.size()), 64'(kept));
    check("abort_byte0", got_q[0], mem[32'h300]);
    check("abort_byte1", got_q[1], mem[32'h301]);
    got_q.delete();
    dump = 1'b1;
    repeat (2) @(posedge clock4);
    fill_random(32'h0004_0000, 3);
    send_header(32'h0004_0000, 32'd3, 4, 1'b1);
    wait_idle("after_abort", 1'b0);
    compare_run("after_abort", 32'h0004_0000, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
